// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divider sequencer around a single 32-bit add/sub unit.
// Serves DIV/DIVU/REM/REMU next to the ALU: one trial subtraction per cycle,
// result held on o_quot/o_rem until the consumer takes it.
// Optional feature macro: DIV_SIGNED_EN (signed operands, FIX state).

// 32-bit add/sub with carry-out and overflow. Carry-lookahead structure is
// left to synthesis; add_sub=1 inverts b so carry_in=1 gives a - b.
module i_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_sub,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum_dif,
    output logic             c,
    output logic             v
);
    logic [WIDTH-1:0] b_x;

    // Conditionally invert b, add, and derive signed overflow.
    always_comb begin
        b_x          = add_sub ? ~b : b;
        {c, sum_dif} = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, carry_in};
        v            = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum_dif[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_signed,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_div_zero,
    output logic             o_busy
);
`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;   // partial remainder (its msb is the 33rd bit of the shifted value)
    logic [WIDTH-1:0] q_r;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_r;     // divisor magnitude

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic sgn_r, neg_q_r, neg_r_r;
    assign dvd_neg = i_signed & i_dividend[WIDTH-1];
    assign dvs_neg = i_signed & i_divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign dvs_abs = dvs_neg ? (~i_divisor + 1'b1) : i_divisor;
`else
    logic signed_unused;
    assign signed_unused = i_signed;
    assign dvd_abs       = i_dividend;
    assign dvs_abs       = i_divisor;
`endif

    // Trial subtraction: shift one dividend bit into the remainder, subtract d.
    logic             msb;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] sum_dif;
    logic             add_c;
    logic             adder_v_unused;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] q_nx;

    assign msb = rem_r[WIDTH-1];
    assign t   = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};

    i_adder #(.WIDTH(WIDTH)) u_add (
        .a        (t),
        .b        (d_r),
        .add_sub  (1'b1),
        .carry_in (1'b1),
        .sum_dif  (sum_dif),
        .c        (add_c),
        .v        (adder_v_unused)
    );

    // A set shifted-out msb means the 33-bit value already exceeds d.
    assign qbit   = add_c | msb;
    assign rem_nx = qbit ? sum_dif : t;
    assign q_nx   = {q_r[WIDTH-2:0], qbit};

    // Sequencer: state, datapath registers and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rem_r      <= '0;
            q_r        <= '0;
            d_r        <= '0;
            o_valid    <= 1'b0;
            o_quot     <= '0;
            o_rem      <= '0;
            o_div_zero <= 1'b0;
            o_busy     <= 1'b0;
            o_ready    <= 1'b1;
`ifdef DIV_SIGNED_EN
            sgn_r      <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Flush is meaningless here; an accept always wins.
                    if (i_valid) begin
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        if (i_divisor == '0) begin
                            state      <= DONE;
                            o_valid    <= 1'b1;
                            o_quot     <= '1;
                            o_rem      <= i_dividend;
                            o_div_zero <= 1'b1;
                        end else begin
                            state      <= RUN;
                            rem_r      <= '0;
                            q_r        <= dvd_abs;
                            d_r        <= dvs_abs;
                            cnt        <= '0;
                            o_div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                            sgn_r      <= i_signed;
                            neg_q_r    <= dvd_neg ^ dvs_neg;
                            neg_r_r    <= dvd_neg;
`endif
                        end
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        rem_r <= rem_nx;
                        q_r   <= q_nx;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
                            if (sgn_r) begin
                                state <= FIX;
                            end else begin
                                state   <= DONE;
                                o_valid <= 1'b1;
                                o_quot  <= q_nx;
                                o_rem   <= rem_nx;
                            end
`else
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_quot  <= q_nx;
                            o_rem   <= rem_nx;
`endif
                        end
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (i_flush) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        // Restore signs: quotient by sign mismatch, remainder follows dividend.
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_quot  <= neg_q_r ? (~q_r + 1'b1) : q_r;
                        o_rem   <= neg_r_r ? (~rem_r + 1'b1) : rem_r;
                    end
                end
`endif
                DONE: begin
                    // Flush drops the pending result exactly like a consume.
                    if (i_flush || i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
